// File: rtl/temp_pkg.sv
// -----------------------------------------------------------------------------
// temp_pkg
// Shared definitions for the temperature-threshold flag producer.
//   - level_t and the level codes LVL_NONE..LVL_CORP. The encoding matches the
//     alarm FSM state codes, so a committed level maps 1:1 onto an FSM state.
//   - Default threshold, hysteresis, debounce and timeout constants.
//   - min_level(): smaller of two level codes.
// -----------------------------------------------------------------------------
package temp_pkg;

    typedef logic [2:0] level_t;

    localparam level_t LVL_NONE = 3'd0;
    localparam level_t LVL_25   = 3'd1;
    localparam level_t LVL_27   = 3'd2;
    localparam level_t LVL_30   = 3'd3;
    localparam level_t LVL_CORP = 3'd4;

    localparam int unsigned T25_DEF         = 25;
    localparam int unsigned T27_DEF         = 27;
    localparam int unsigned T30_DEF         = 30;
    localparam int unsigned TCORP_DEF       = 37;
    localparam int unsigned HYST_DEF        = 1;
    localparam int unsigned DEB_COUNT_DEF   = 3;
    localparam int unsigned TIMEOUT_CYC_DEF = 50000000;

    function automatic level_t min_level(input level_t a, input level_t b);
        return (a < b) ? a : b;
    endfunction

endpackage : temp_pkg

// File: rtl/temp_level_quant.sv
// -----------------------------------------------------------------------------
// temp_level_quant
// Combinational quantizer: maps an unsigned DW+1-bit temperature onto a level
// code. The extra bit lets the caller present T+HYST without wrapping.
//   value_i  in  DW+1  temperature in degrees C
//   level_o  out 3     0 below T25, 1 below T27, 2 below T30, 3 below TCORP,
//                      otherwise 4
// Thresholds must be strictly increasing.
// -----------------------------------------------------------------------------
module temp_level_quant
    import temp_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned T25   = T25_DEF,
    parameter int unsigned T27   = T27_DEF,
    parameter int unsigned T30   = T30_DEF,
    parameter int unsigned TCORP = TCORP_DEF
) (
    input  logic [DW:0] value_i,
    output level_t      level_o
);

    localparam logic [DW:0] TH_25   = T25[DW:0];
    localparam logic [DW:0] TH_27   = T27[DW:0];
    localparam logic [DW:0] TH_30   = T30[DW:0];
    localparam logic [DW:0] TH_CORP = TCORP[DW:0];

    // NOTE: every path of the if/else chain assigns level_o, so no latch can be
    // inferred; any always_comb output must be written on all paths.
    always_comb begin
        if (value_i < TH_25) begin
            level_o = LVL_NONE;
        end else if (value_i < TH_27) begin
            level_o = LVL_25;
        end else if (value_i < TH_30) begin
            level_o = LVL_27;
        end else if (value_i < TH_CORP) begin
            level_o = LVL_30;
        end else begin
            level_o = LVL_CORP;
        end
    end

endmodule : temp_level_quant

// File: rtl/temp_threshold_gen.sv
// -----------------------------------------------------------------------------
// temp_threshold_gen
// Turns sampled sensor temperatures into debounced one-hot threshold flags for
// the alarm FSM. A sensor that goes silent for TIMEOUT_CYC clocks forces the
// level back to 0 and raises sensor_fault.
//
// Ports
//   clk           in   1   system clock
//   reset         in   1   asynchronous, active-low reset
//   temp_data     in   DW  sensor temperature, unsigned degrees C
//   temp_valid    in   1   one-cycle strobe, temp_data sampled when high
//   t_25..t_corp  out  1   registered one-hot decode of the committed level
//   level         out  3   committed level code 0..4
//   sensor_fault  out  1   set on timeout, cleared by the next temp_valid
//
// Build option
//   TEMP_HYST_EN  when defined, a falling reading must also be lower by HYST
//                 before it can pull the level down. When undefined the
//                 candidate level is simply q(temp_data) and HYST is unused.
// -----------------------------------------------------------------------------
module temp_threshold_gen
    import temp_pkg::*;
#(
    parameter int unsigned DW          = 8,
    parameter int unsigned T25         = T25_DEF,
    parameter int unsigned T27         = T27_DEF,
    parameter int unsigned T30         = T30_DEF,
    parameter int unsigned TCORP       = TCORP_DEF,
    parameter int unsigned HYST        = HYST_DEF,
    parameter int unsigned DEB_COUNT   = DEB_COUNT_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] temp_data,
    input  logic          temp_valid,
    output logic          t_25,
    output logic          t_27,
    output logic          t_30,
    output logic          t_corp,
    output level_t        level,
    output logic          sensor_fault
);

    if (DEB_COUNT < 1 || TIMEOUT_CYC < 1 || HYST >= (64'd1 << DW) ||
        !(T25 < T27 && T27 < T30 && T30 < TCORP)) begin : g_bad_params
        $error("temp_threshold_gen: illegal parameter set");
    end

    localparam int unsigned DEB_W = $clog2(DEB_COUNT + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    localparam int unsigned ONE_I      = 1;
    localparam int unsigned TMO_LAST_I = TIMEOUT_CYC - 1;

    localparam logic [DEB_W-1:0] DEB_ONE  = ONE_I[DEB_W-1:0];
    localparam logic [DEB_W-1:0] DEB_MAX  = DEB_COUNT[DEB_W-1:0];
    localparam logic [TMO_W-1:0] TMO_ONE  = ONE_I[TMO_W-1:0];
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_LAST_I[TMO_W-1:0];
    localparam logic [TMO_W-1:0] TMO_SAT  = TIMEOUT_CYC[TMO_W-1:0];

    level_t           level_q, level_d;
    level_t           pend_q, pend_d;
    logic [DEB_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             fault_q, fault_d;
    logic             t25_q, t27_q, t30_q, tcorp_q;

    // ---------------------------------------------------------------- candidate
    logic [DW:0] temp_ext;
    level_t      q_raw;
    level_t      cand;

    assign temp_ext = {1'b0, temp_data};

    temp_level_quant #(
        .DW(DW), .T25(T25), .T27(T27), .T30(T30), .TCORP(TCORP)
    ) u_quant_raw (
        .value_i (temp_ext),
        .level_o (q_raw)
    );

`ifdef TEMP_HYST_EN
    localparam logic [DW:0] HYST_W = HYST[DW:0];

    logic [DW:0] temp_hyst;
    level_t      q_hyst;

    // One extra bit keeps T+HYST from wrapping at the top of the sensor range.
    assign temp_hyst = temp_ext + HYST_W;

    temp_level_quant #(
        .DW(DW), .T25(T25), .T27(T27), .T30(T30), .TCORP(TCORP)
    ) u_quant_hyst (
        .value_i (temp_hyst),
        .level_o (q_hyst)
    );

    // Rising readings take effect at face value; a falling reading only counts
    // once it is below the threshold by HYST, and never raises the level.
    assign cand = (q_raw >= level_q) ? q_raw : min_level(level_q, q_hyst);
`else
    assign cand = q_raw;
`endif

    // ------------------------------------------------------- debounce / timeout
    always_comb begin
        level_d = level_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        fault_d = fault_q;

        if (temp_valid) begin
            // A valid sample always wins over a coincident timeout expiry.
            tmo_d   = '0;
            fault_d = 1'b0;
            if (cand == level_q) begin
                cnt_d = '0;
            end else if (cand != pend_q) begin
                pend_d = cand;
                cnt_d  = DEB_ONE;
            end else begin
                cnt_d = cnt_q + DEB_ONE;
            end
            if (cnt_d == DEB_MAX) begin
                level_d = pend_d;
                cnt_d   = '0;
            end
        end else if (tmo_q == TMO_LAST) begin
            level_d = LVL_NONE;
            pend_d  = LVL_NONE;
            cnt_d   = '0;
            tmo_d   = TMO_SAT;
            fault_d = 1'b1;
        end else if (tmo_q != TMO_SAT) begin
            tmo_d = tmo_q + TMO_ONE;
        end
    end

    // NOTE: all state here is plain flops, so every register (counters
    // included) gets an async reset value; there is no memory array to exempt.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_q <= LVL_NONE;
            pend_q  <= LVL_NONE;
            cnt_q   <= '0;
            tmo_q   <= '0;
            fault_q <= 1'b0;
            t25_q   <= 1'b0;
            t27_q   <= 1'b0;
            t30_q   <= 1'b0;
            tcorp_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values computed above, independent of statement order.
            level_q <= level_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            fault_q <= fault_d;
            // Flags decode level_d so they change on the same edge as level.
            t25_q   <= (level_d == LVL_25);
            t27_q   <= (level_d == LVL_27);
            t30_q   <= (level_d == LVL_30);
            tcorp_q <= (level_d == LVL_CORP);
        end
    end

    assign level        = level_q;
    assign sensor_fault = fault_q;
    assign t_25         = t25_q;
    assign t_27         = t27_q;
    assign t_30         = t30_q;
    assign t_corp       = tcorp_q;

endmodule : temp_threshold_gen

// File: tb/tb_temp_threshold_gen.sv
// -----------------------------------------------------------------------------
// tb_temp_threshold_gen
// Scoreboard bench for temp_threshold_gen. The driver applies one input per
// clock, advances a reference model written from the threshold/debounce/
// timeout rules, and queues the expected outputs after that edge. A monitor
// pops one entry per clock, shortly after the edge, and compares.
// -----------------------------------------------------------------------------
module tb_temp_threshold_gen;

    localparam int DW   = 8;
    localparam int DEB  = 3;
    localparam int HYST = 1;
    localparam int TMO  = 100;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] temp_data = '0;
    logic          temp_valid = 1'b0;
    logic          t_25, t_27, t_30, t_corp;
    logic [2:0]    level;
    logic          sensor_fault;

    temp_threshold_gen #(
        .DW(DW), .HYST(HYST), .DEB_COUNT(DEB), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .temp_data    (temp_data),
        .temp_valid   (temp_valid),
        .t_25         (t_25),
        .t_27         (t_27),
        .t_30         (t_30),
        .t_corp       (t_corp),
        .level        (level),
        .sensor_fault (sensor_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   lvl;
        logic fault;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // ----------------------------------------------------- reference model
    int m_level;
    int m_run[$];   // current run of identical candidates that differ from level
    int m_idle;     // clocks since the last valid sample
    bit m_fault;

    function automatic int quant(input int x);
        if (x < 25) return 0;
        if (x < 27) return 1;
        if (x < 30) return 2;
        if (x < 37) return 3;
        return 4;
    endfunction

    function automatic int candidate(input int t);
`ifdef TEMP_HYST_EN
        int qt, qh;
        qt = quant(t);
        if (qt >= m_level) return qt;
        qh = quant(t + HYST);
        return (qh < m_level) ? qh : m_level;
`else
        return quant(t);
`endif
    endfunction

    task automatic model_reset();
        m_level = 0;
        m_run.delete();
        m_idle  = 0;
        m_fault = 1'b0;
    endtask

    task automatic model_step(input bit v, input int d);
        int c;
        if (v) begin
            m_idle  = 0;
            m_fault = 1'b0;
            c = candidate(d);
            if (c == m_level) begin
                m_run.delete();
            end else begin
                if (m_run.size() > 0 && m_run[$] != c) m_run.delete();
                m_run.push_back(c);
                if (m_run.size() == DEB) begin
                    m_level = c;
                    m_run.delete();
                end
            end
        end else begin
            m_idle++;
            if (m_idle == TMO) begin
                m_level = 0;
                m_run.delete();
                m_fault = 1'b1;
            end
        end
    endtask

    // -------------------------------------------------------------- checking
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [3:0] onehot(input int lvl);
        logic [3:0] f;
        f[0] = (lvl == 1);
        f[1] = (lvl == 2);
        f[2] = (lvl == 3);
        f[3] = (lvl == 4);
        return f;
    endfunction

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("level", 32'(level), 32'(e.lvl));
            check("flags", 32'({t_corp, t_30, t_27, t_25}), 32'(onehot(e.lvl)));
            check("sensor_fault", 32'(sensor_fault), 32'(e.fault));
        end
    end

    // ------------------------------------------------------------- stimulus
    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input bit v, input int d);
        exp_t e;
        temp_valid = v;
        temp_data  = DW'(d);
        model_step(v, d);
        e.lvl   = m_level;
        e.fault = m_fault;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic samples(input int d, input int n);
        repeat (n) step(1'b1, d);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0);
    endtask

    task automatic seq(input int vals[$]);
        foreach (vals[i]) step(1'b1, vals[i]);
    endtask

    // Asserts reset between clock edges and checks the outputs clear at once.
    task automatic do_reset(input string tag);
        #7;
        reset      = 1'b0;
        temp_valid = 1'b0;
        #1;
        check({tag, "_level"}, 32'(level), 32'd0);
        check({tag, "_flags"}, 32'({t_corp, t_30, t_27, t_25}), 32'd0);
        check({tag, "_fault"}, 32'(sensor_fault), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        int table_v[14] = '{0, 24, 25, 26, 27, 28, 29, 30, 31, 36, 37, 38, 40, 255};
        model_reset();

        // Power-on reset.
        #1 reset = 1'b0;
        #1;
        check("por_level", 32'(level), 32'd0);
        check("por_flags", 32'({t_corp, t_30, t_27, t_25}), 32'd0);
        check("por_fault", 32'(sensor_fault), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        idle(2);

        // Debounce: two samples are not enough, the third commits.
        samples(28, 2);
        samples(28, 1);

        // Falling readings near level 2 (hysteresis build holds at 26).
        samples(26, 3);
        samples(25, 3);

        // Interrupted debounce, then reset while t_30 is high.
        do_reset("rst_a");
        seq('{31, 31, 24, 31, 31, 31});
        do_reset("rst_t30");

        // Direct jump 0 -> 4, then sensor silence.
        samples(40, 3);
        idle(TMO + 3);
        samples(40, 3);

        // Top of range at level 4, then valid coincident with expiry.
        samples(255, 3);
        idle(TMO - 1);
        step(1'b1, 40);
        idle(5);

        // Reset in the middle of a debounce run.
        samples(28, 2);
        do_reset("rst_deb");
        samples(28, 1);
        samples(28, 2);

        // Randomised bursts around the thresholds with occasional silence.
        for (int i = 0; i < 300; i++) begin
            int d, n;
            d = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 255))
                                            : table_v[$urandom_range(0, 13)];
            n = $urandom_range(1, 4);
            samples(d, n);
            if ($urandom_range(0, 29) == 0) idle(TMO + int'($urandom_range(0, 3)));
            else if ($urandom_range(0, 29) == 1) idle(TMO - 1);
            else idle($urandom_range(0, 2));
        end

        idle(1);
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_temp_threshold_gen
